display_source_scheduler: RTL

- Time-shares the board's single 8-digit hex display between N_SRC 32-bit debug sources: PC, ALU result, register-file probe, HLS accelerator output.
- Sits between the processor and the 7-segment display driver. It drives that driver's 32-bit data word and its integer/Q16.16 mode bit.
- Source selection is manual (debounced push-button) or automatic (timed rotation). A freeze button holds the shown value.

---
 rtl/display_source_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/display_source_scheduler.sv
// display_source_scheduler
//   Time-shares one 8-digit hex display between N_SRC 32-bit debug sources.
//   Selection is manual (debounced btn_next) or automatic (timed rotation when
//   auto_en is high). btn_freeze toggles a hold on the displayed value.
//
//   Optional build macro DISP_SRC_TAG_EN: when defined, data_out[31:28]
//   carries the zero-extended source index and data_out[27:0] the low 28 bits
//   of the selected word. When undefined, the word passes through untouched.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   src_data        packed source words, source k at [32k+31:32k]
//   src_mode        per-source format bit (0 integer, 1 Q16.16)
//   btn_next        raw push-button, advance to next source
//   btn_freeze      raw push-button, toggle freeze
//   auto_en         slide switch, 1 = auto-rotate
//   data_out        word to the display driver
//   mode_out        format bit to the display driver
//   src_sel         index of the currently selected source
//   frozen          high while the display is held

// Synchronizer + debouncer for one raw button. Emits a single-cycle pulse on
// the accepted rising edge; release is accepted silently.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          acc;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      acc   <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      pulse <= 1'b0;
      // Count only while the synchronized level disagrees with the accepted
      // one; any return to agreement restarts the stability window.
      if (sync[1] == acc) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        acc   <= sync[1];
        cnt   <= '0;
        pulse <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module display_source_scheduler #(
  parameter int N_SRC           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DWELL_CYCLES    = 200000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [32*N_SRC-1:0]      src_data,
  input  logic [N_SRC-1:0]         src_mode,
  input  logic                     btn_next,
  input  logic                     btn_freeze,
  input  logic                     auto_en,
  output logic [31:0]              data_out,
  output logic                     mode_out,
  output logic [$clog2(N_SRC)-1:0] src_sel,
  output logic                     frozen
);
  localparam int SW = $clog2(N_SRC);
  localparam int DW = $clog2(DWELL_CYCLES + 1);

  typedef enum logic [1:0] {RUN_MANUAL, RUN_AUTO, FROZEN} state_t;

  state_t        state;
  logic [DW-1:0] dwell;
  logic [1:0]    auto_sync;
  logic          auto_s;
  logic [1:0]    btn_raw;
  logic [1:0]    btn_p;
  logic          next_p;
  logic          frz_p;
  logic [SW-1:0] sel_adv;
  logic [31:0]   word;

  // Button conditioning: lane 0 = next, lane 1 = freeze.
  assign btn_raw = {btn_freeze, btn_next};
  assign next_p  = btn_p[0];
  assign frz_p   = btn_p[1];

  generate
    for (genvar i = 0; i < 2; i++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_raw[i]),
        .pulse (btn_p[i])
      );
    end
  endgenerate

  // Level switch: synchronized only, bounce on a slide switch is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) auto_sync <= '0;
    else        auto_sync <= {auto_sync[0], auto_en};
  end
  assign auto_s = auto_sync[1];

  // Explicit wrap so non-power-of-two N_SRC never selects a missing source.
  assign sel_adv = (src_sel == SW'(N_SRC - 1)) ? '0 : src_sel + SW'(1);
  assign frozen  = (state == FROZEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN_MANUAL;
      dwell   <= '0;
      src_sel <= '0;
    end else begin
      case (state)
        FROZEN: begin
          if (frz_p) begin
            state <= auto_s ? RUN_AUTO : RUN_MANUAL;
            dwell <= '0;
          end
        end
        default: begin
          // Freeze has priority over any same-cycle advance.
          if (frz_p) begin
            state <= FROZEN;
          end else begin
            state <= auto_s ? RUN_AUTO : RUN_MANUAL;
            if (state == RUN_AUTO && auto_s) begin
              // Manual press and dwell expiry together give one advance.
              if (next_p || dwell == DW'(DWELL_CYCLES - 1)) begin
                src_sel <= sel_adv;
                dwell   <= '0;
              end else begin
                dwell <= dwell + DW'(1);
              end
            end else begin
              // Manual mode, or the cycle auto_en changes: dwell restarts.
              dwell <= '0;
              if (next_p) src_sel <= sel_adv;
            end
          end
        end
      endcase
    end
  end

  assign word = src_data[32*int'(src_sel) +: 32];

  // Output register follows the registered src_sel; holds while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      mode_out <= 1'b0;
    end else if (state != FROZEN) begin
`ifdef DISP_SRC_TAG_EN
      data_out <= {4'(src_sel), word[27:0]};
`else
      data_out <= word;
`endif
      mode_out <= src_mode[src_sel];
    end
  end
endmodule
